// File: rtl/ext_bus_responder_pkg.sv
// ---------------------------------------------------------------------------
// ext_bus_responder_pkg
// Shared definitions for the external bus responder slice:
//   - CPU bus phase encodings (address-low/rw phase vs address-high/data phase)
//   - position and meaning of the rw bit on the data lines in phase 0
//   - responder state encoding
//   - window hit helper used by the address decoder
// ---------------------------------------------------------------------------
package ext_bus_responder_pkg;

    localparam logic PH_ADDR_LO = 1'b0;
    localparam logic PH_ADDR_HI = 1'b1;

    localparam int   RW_BIT   = 0;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        S_SYNC,
        S_LO,
        S_HI_RD,
        S_HI_WR,
        S_HI_MISS
    } busState_e;

    // An address hits the window when every bit above the RAM index field
    // matches the base. With aw >= 16 the whole 64K space is the window.
    function automatic logic addrHit(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int          aw);
        logic [15:0] mask;
        mask = (aw >= 16) ? 16'h0000 : (16'hFFFF << aw);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/ext_bus_responder_mem.sv
// ---------------------------------------------------------------------------
// ext_bus_responder_mem
// 2^AW x 8 byte RAM with one synchronous write port and two synchronous,
// individually enabled read ports (bus side and host side). Write arbitration
// is done by the parent; this block simply performs what it is given.
// The array itself is never reset so preloaded contents survive rst_n; only
// the read data registers are cleared.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset (read registers only)
//   we_i          write enable
//   waddr_i       write address
//   wdata_i       write data
//   busRe_i       bus read enable, loads busRdata_o at the clock edge
//   busRaddr_i    bus read address
//   busRdata_o    registered bus read data (holds when busRe_i is low)
//   hostRe_i      host read enable, loads hostRdata_o at the clock edge
//   hostRaddr_i   host read address
//   hostRdata_o   registered host read data (holds when hostRe_i is low)
// ---------------------------------------------------------------------------
module ext_bus_responder_mem #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          busRe_i,
    input  logic [AW-1:0] busRaddr_i,
    output logic [7:0]    busRdata_o,
    input  logic          hostRe_i,
    input  logic [AW-1:0] hostRaddr_i,
    output logic [7:0]    hostRdata_o
);

    logic [7:0] mem_q [2**AW];
    logic [7:0] busRdata_q;
    logic [7:0] hostRdata_q;

    // Reads below see the pre-write contents when a read and a write
    // target the same byte on the same edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busRdata_q <= 8'h00;
        end else if (busRe_i) begin
            busRdata_q <= mem_q[busRaddr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hostRdata_q <= 8'h00;
        end else if (hostRe_i) begin
            hostRdata_q <= mem_q[hostRaddr_i];
        end
    end

    assign busRdata_o  = busRdata_q;
    assign hostRdata_o = hostRdata_q;

endmodule

// File: rtl/ext_bus_responder.sv
// ---------------------------------------------------------------------------
// ext_bus_responder
// Target-side partner of the CPU's multiplexed external bus, running on the
// fast system clock. The CPU presents the low address byte (with rw on data
// bit 0) while phase is 0 and the high address byte while phase is 1; in
// phase 1 the data lines carry write data or the responder drives read data.
// Reads are served from an internal byte RAM, writes are committed at the end
// of phase 1, and a host port can preload/inspect the RAM while holding the
// bus responder off.
//
// Ports:
//   clk           system clock (also generates the CPU phase)
//   rst_n         synchronous active-low reset
//   phase         CPU bus phase: 0 = address-low/rw, 1 = address-high/data
//   bus_addr_in   multiplexed address byte from the CPU
//   bus_data_in   CPU data lines (rw in bit 0 in phase 0, write data in phase 1)
//   bus_data_out  read data toward the CPU
//   bus_data_oe   responder drives the data lines
//   host_en       host owns the RAM; bus responses suppressed
//   host_we       host write strobe
//   host_addr     host address
//   host_wdata    host write data
//   host_rdata    host read data, one clock latency
//   last_addr     address of the most recently decoded access
//   rd_count      completed in-window reads (wraps)
//   wr_count      completed in-window writes (wraps)
//   miss          last decoded access was outside the window
// ---------------------------------------------------------------------------
module ext_bus_responder
    import ext_bus_responder_pkg::*;
#(
    parameter int          AW   = 8,
    parameter logic [15:0] BASE = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          phase,
    input  logic [7:0]    bus_addr_in,
    input  logic [7:0]    bus_data_in,
    output logic [7:0]    bus_data_out,
    output logic          bus_data_oe,
    input  logic          host_en,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic [15:0]   last_addr,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count,
    output logic          miss
);

    busState_e     state_q;
    logic          phase_q;
    logic          hostEn_q;
    logic [7:0]    addrLo_q;
    logic          rw_q;
    logic [7:0]    wdata_q;
    logic [15:0]   lastAddr_q;
    logic [15:0]   rdCount_q;
    logic [15:0]   wrCount_q;
    logic          miss_q;
    logic          oe_q;

    logic          rise;
    logic          fall;
    logic [15:0]   decodeAddr;
    logic          decodeHit;

    logic          memWe;
    logic [AW-1:0] memWaddr;
    logic [7:0]    memWdata;
    logic          busRe;
    logic          hostRe;

    assign rise = (phase == PH_ADDR_HI) && (phase_q == PH_ADDR_LO);
    assign fall = (phase == PH_ADDR_LO) && (phase_q == PH_ADDR_HI);

    // The high byte is taken straight off the pins on the rise clock; the low
    // byte is whatever was last seen during phase 0.
    assign decodeAddr = {bus_addr_in, addrLo_q};
    assign decodeHit  = addrHit(decodeAddr, BASE, AW);

    // The RAM read for a bus read is launched on the rise clock itself, so the
    // data register and bus_data_oe come up together one clock after rise.
    assign busRe  = rst_n && !host_en && (state_q == S_LO) && rise &&
                    decodeHit && (rw_q == RW_READ);
    assign hostRe = rst_n && host_en;

    // Host owns the write port while host_en is high; otherwise a bus write
    // commits on the fall clock using the data captured on the last phase-1
    // clock. Reset blocks every write so an interrupted access leaves no trace.
    always_comb begin
        memWe    = 1'b0;
        memWaddr = lastAddr_q[AW-1:0];
        memWdata = wdata_q;
        if (rst_n) begin
            if (host_en) begin
                memWe    = host_we;
                memWaddr = host_addr;
                memWdata = host_wdata;
            end else if ((state_q == S_HI_WR) && fall) begin
                memWe    = 1'b1;
            end
        end
    end

    ext_bus_responder_mem #(
        .AW (AW)
    ) u_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_i        (memWe),
        .waddr_i     (memWaddr),
        .wdata_i     (memWdata),
        .busRe_i     (busRe),
        .busRaddr_i  (decodeAddr[AW-1:0]),
        .busRdata_o  (bus_data_out),
        .hostRe_i    (hostRe),
        .hostRaddr_i (host_addr),
        .hostRdata_o (host_rdata)
    );

    // Bus protocol state machine. S_SYNC swallows any partial bus cycle after
    // reset or host release: decoding only starts after a clean fall, and a
    // fall on the very clock host_en drops does not count (hostEn_q).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_SYNC;
            phase_q    <= 1'b0;
            hostEn_q   <= 1'b0;
            addrLo_q   <= 8'h00;
            rw_q       <= 1'b0;
            wdata_q    <= 8'h00;
            lastAddr_q <= 16'h0000;
            rdCount_q  <= 16'h0000;
            wrCount_q  <= 16'h0000;
            miss_q     <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            phase_q  <= phase;
            hostEn_q <= host_en;

            // Low address and rw track the pins for the whole of phase 0;
            // the value from the last phase-0 clock is the one decoded.
            if (phase == PH_ADDR_LO) begin
                addrLo_q <= bus_addr_in;
                rw_q     <= bus_data_in[RW_BIT];
            end

            if (host_en) begin
                state_q <= S_SYNC;
                oe_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_SYNC: begin
                        if (fall && !hostEn_q) begin
                            state_q <= S_LO;
                        end
                    end
                    S_LO: begin
                        if (rise) begin
                            lastAddr_q <= decodeAddr;
                            miss_q     <= !decodeHit;
                            if (!decodeHit) begin
                                state_q <= S_HI_MISS;
                            end else if (rw_q == RW_READ) begin
                                oe_q    <= 1'b1;
                                state_q <= S_HI_RD;
                            end else begin
                                state_q <= S_HI_WR;
                            end
                        end
                    end
                    S_HI_RD: begin
                        // Drive through the fall-detect clock for hold time
                        // past the CPU's latch edge.
                        if (fall) begin
                            oe_q      <= 1'b0;
                            rdCount_q <= rdCount_q + 16'd1;
                            state_q   <= S_LO;
                        end
                    end
                    S_HI_WR: begin
                        wdata_q <= bus_data_in;
                        if (fall) begin
                            wrCount_q <= wrCount_q + 16'd1;
                            state_q   <= S_LO;
                        end
                    end
                    S_HI_MISS: begin
                        if (fall) begin
                            state_q <= S_LO;
                        end
                    end
                    default: begin
                        state_q <= S_SYNC;
                        oe_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus_data_oe = oe_q;
    assign last_addr   = lastAddr_q;
    assign rd_count    = rdCount_q;
    assign wr_count    = wrCount_q;
    assign miss        = miss_q;

    // Only rw_q == RW_WRITE leads to S_HI_WR, where oe stays low.
    logic unusedRwWrite;
    assign unusedRwWrite = (rw_q == RW_WRITE) & 1'b0;

endmodule

// File: tb/tb_ext_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_ext_bus_responder
// Drives CPU bus cycles with randomized phase lengths and address-low noise,
// host preload/inspect operations, resets and host aborts, and compares the
// responder outputs every clock against a transaction-level model of the bus
// protocol. A few hand-computed literals pin the model on known scenarios.
// ---------------------------------------------------------------------------
module tb_ext_bus_responder;

    localparam int          AW   = 8;
    localparam logic [15:0] BASE = 16'h0000;

    localparam int P_NONE  = 0;
    localparam int P_READ  = 1;
    localparam int P_WRITE = 2;
    localparam int P_MISS  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          phase;
    logic [7:0]    bus_addr_in;
    logic [7:0]    bus_data_in;
    logic [7:0]    bus_data_out;
    logic          bus_data_oe;
    logic          host_en;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic [7:0]    host_rdata;
    logic [15:0]   last_addr;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;
    logic          miss;

    always #5 clk = ~clk;

    ext_bus_responder #(
        .AW   (AW),
        .BASE (BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .phase        (phase),
        .bus_addr_in  (bus_addr_in),
        .bus_data_in  (bus_data_in),
        .bus_data_out (bus_data_out),
        .bus_data_oe  (bus_data_oe),
        .host_en      (host_en),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .last_addr    (last_addr),
        .rd_count     (rd_count),
        .wr_count     (wr_count),
        .miss         (miss)
    );

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;

    // Values driven for the current clock
    logic       curRst, curPhase, curHost, curWe;
    logic [7:0] curAddr, curData, curHaddr, curHwdata;

    // Behavioural model
    logic [7:0]  modelMem [2**AW];
    logic [15:0] mRd, mWr, mLast;
    logic        mMiss, mOe;
    logic [7:0]  mData, mHostR;
    bit          synced;
    int          pendKind;
    logic [15:0] pendAddr;
    logic [7:0]  pendWdata;
    logic [7:0]  loAddr;
    logic        loRw;
    logic        prevPhase, prevHost;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of bus protocol in transaction terms: a decoded access is
    // pending from the rise that decoded it to the fall that retires it.
    function automatic void modelTick();
        logic        rise, fall, hit;
        logic [15:0] a;
        if (!curRst) begin
            mOe = 1'b0; mData = 8'h00; mHostR = 8'h00; mLast = 16'h0000;
            mRd = 16'h0000; mWr = 16'h0000; mMiss = 1'b0;
            synced = 1'b0; pendKind = P_NONE;
            prevPhase = 1'b0; prevHost = 1'b0;
            return;
        end
        rise = curPhase && !prevPhase;
        fall = !curPhase && prevPhase;
        if (curHost) begin
            mHostR = modelMem[curHaddr];
            if (curWe) modelMem[curHaddr] = curHwdata;
            synced = 1'b0; pendKind = P_NONE; mOe = 1'b0;
        end else if (!synced) begin
            if (fall && !prevHost) synced = 1'b1;
        end else if (pendKind == P_NONE) begin
            if (rise) begin
                a = {curAddr, loAddr};
                hit = ((a >> AW) == (BASE >> AW));
                mLast = a; mMiss = !hit; pendAddr = a;
                if (!hit) pendKind = P_MISS;
                else if (loRw) begin
                    pendKind = P_READ; mOe = 1'b1; mData = modelMem[a[AW-1:0]];
                end else pendKind = P_WRITE;
            end
        end else if (fall) begin
            if (pendKind == P_READ) begin
                mOe = 1'b0; mRd++;
            end else if (pendKind == P_WRITE) begin
                modelMem[pendAddr[AW-1:0]] = pendWdata; mWr++;
            end
            pendKind = P_NONE;
        end else if (curPhase) begin
            pendWdata = curData;
        end
        if (!curPhase) begin
            loAddr = curAddr; loRw = curData[0];
        end
        prevPhase = curPhase; prevHost = curHost;
    endfunction

    task automatic applyStimulus();
        rst_n = curRst; phase = curPhase; bus_addr_in = curAddr; bus_data_in = curData;
        host_en = curHost; host_we = curWe; host_addr = curHaddr; host_wdata = curHwdata;
        @(posedge clk);
        #1;
        modelTick();
    endtask

    task automatic tickWith(input logic ph, input logic [7:0] addr, input logic [7:0] data);
        curPhase = ph; curAddr = addr; curData = data; curHost = 1'b0; curWe = 1'b0;
        applyStimulus();
    endtask

    task automatic busCycle(input logic [15:0] addr, input logic rw, input logic [7:0] wdata,
                            output logic [7:0] seenData, output logic seenOe);
        int n0 = $urandom_range(2, 4);
        int n1 = $urandom_range(2, 4);
        seenData = 8'h00; seenOe = 1'b0;
        for (int i = 0; i < n0; i++) begin
            if (i == n0 - 1) tickWith(1'b0, addr[7:0], {7'($urandom), rw});
            else             tickWith(1'b0, 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < n1; i++) begin
            tickWith(1'b1, addr[15:8], (i == n1 - 1) ? wdata : 8'($urandom));
            if (i == 0) begin
                seenData = bus_data_out; seenOe = bus_data_oe;
            end
        end
    endtask

    task automatic finishCycle();
        for (int i = 0; i < 2; i++) tickWith(1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic parkHigh();
        for (int i = 0; i < 2; i++) tickWith(1'b1, 8'($urandom), 8'($urandom));
    endtask

    task automatic hostWrite(input logic [7:0] a, input logic [7:0] d);
        curHost = 1'b1; curWe = 1'b1; curHaddr = a; curHwdata = d;
        applyStimulus();
    endtask

    task automatic hostRead(input logic [7:0] a, output logic [7:0] d);
        curHost = 1'b1; curWe = 1'b0; curHaddr = a;
        applyStimulus();
        d = host_rdata;
    endtask

    task automatic hostRelease();
        curHost = 1'b0; curWe = 1'b0;
        applyStimulus();
    endtask

    task automatic doReset();
        curRst = 1'b0; curHost = 1'b0; curWe = 1'b0;
        applyStimulus();
        applyStimulus();
        curRst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("bus_data_oe",  bus_data_oe,  mOe);
            checkOutput("bus_data_out", bus_data_out, mData);
            checkOutput("rd_count",     rd_count,     mRd);
            checkOutput("wr_count",     wr_count,     mWr);
            checkOutput("last_addr",    last_addr,    mLast);
            checkOutput("miss",         miss,         mMiss);
            checkOutput("host_rdata",   host_rdata,   mHostR);
        end
    end

    initial begin
        logic [7:0]  seenData;
        logic        seenOe;
        logic [7:0]  hr;
        logic [15:0] a;
        int          r;

        curRst = 1'b0; curPhase = 1'b0; curHost = 1'b0; curWe = 1'b0;
        curAddr = 8'h00; curData = 8'h00; curHaddr = 8'h00; curHwdata = 8'h00;
        loAddr = 8'h00; loRw = 1'b0; pendWdata = 8'h00; pendAddr = 16'h0000;
        doReset();

        // Fill the RAM so every model entry is known
        for (int i = 0; i < 2**AW; i++) hostWrite(8'(i), 8'($urandom));
        hostRead(8'h00, hr);
        hostRelease();
        doReset();
        checkEn = 1'b1;
        checkOutput("reset_rd_count", rd_count, 16'h0000);
        checkOutput("reset_wr_count", wr_count, 16'h0000);
        checkOutput("reset_oe", bus_data_oe, 1'b0);
        checkOutput("reset_last_addr", last_addr, 16'h0000);

        // No fall since reset: this read must be ignored
        busCycle(16'h0033, 1'b1, 8'h00, seenData, seenOe);
        checkOutput("sync_oe", seenOe, 1'b0);
        finishCycle();
        checkOutput("sync_last_addr", last_addr, 16'h0000);
        checkOutput("sync_rd_count", rd_count, 16'h0000);

        // Host preload then two reads
        hostWrite(8'h00, 8'hA9);
        hostWrite(8'h01, 8'h42);
        hostRelease();
        parkHigh();
        busCycle(16'h0000, 1'b1, 8'h00, seenData, seenOe);
        checkOutput("read0_data", seenData, 8'hA9);
        checkOutput("read0_oe", seenOe, 1'b1);
        busCycle(16'h0001, 1'b1, 8'h00, seenData, seenOe);
        checkOutput("read1_data", seenData, 8'h42);
        finishCycle();
        checkOutput("reads_rd_count", rd_count, 16'd2);
        checkOutput("reads_last_addr", last_addr, 16'h0001);
        checkOutput("reads_oe_after", bus_data_oe, 1'b0);

        // Write with data changing during phase 1
        busCycle(16'h0010, 1'b0, 8'h5A, seenData, seenOe);
        checkOutput("write_oe", seenOe, 1'b0);
        finishCycle();
        checkOutput("write_wr_count", wr_count, 16'd1);

        // Out-of-window read, then an in-window read clears miss
        busCycle(16'h0100, 1'b1, 8'h00, seenData, seenOe);
        checkOutput("miss_oe", seenOe, 1'b0);
        finishCycle();
        checkOutput("miss_flag", miss, 1'b1);
        checkOutput("miss_rd_count", rd_count, 16'd2);
        checkOutput("miss_last_addr", last_addr, 16'h0100);
        busCycle(16'h0001, 1'b1, 8'h00, seenData, seenOe);
        finishCycle();
        checkOutput("hit_clears_miss", miss, 1'b0);
        checkOutput("hit_rd_count", rd_count, 16'd3);
        hostRead(8'h10, hr);
        checkOutput("host_read_write_data", hr, 8'h5A);
        hostRelease();

        // Reset in the middle of a write
        hostWrite(8'h20, 8'h11);
        hostRelease();
        parkHigh();
        tickWith(1'b0, 8'h20, 8'h00);
        tickWith(1'b0, 8'h20, 8'h00);
        tickWith(1'b1, 8'h00, 8'h77);
        tickWith(1'b1, 8'h00, 8'h77);
        curPhase = 1'b1;
        doReset();
        checkOutput("rstmid_wr_count", wr_count, 16'h0000);
        checkOutput("rstmid_rd_count", rd_count, 16'h0000);
        checkOutput("rstmid_oe", bus_data_oe, 1'b0);
        parkHigh();
        busCycle(16'h0020, 1'b1, 8'h00, seenData, seenOe);
        checkOutput("rstmid_mem_kept", seenData, 8'h11);
        finishCycle();
        checkOutput("rstmid_next_read", rd_count, 16'd1);

        // rd_count wrap
        force dut.rdCount_q = 16'hFFFF;
        #1;
        release dut.rdCount_q;
        mRd = 16'hFFFF;
        busCycle(16'h0001, 1'b1, 8'h00, seenData, seenOe);
        finishCycle();
        checkOutput("rd_count_wrap", rd_count, 16'h0000);

        // Host takes over mid-read
        tickWith(1'b0, 8'h00, 8'h01);
        tickWith(1'b0, 8'h00, 8'h01);
        tickWith(1'b1, 8'h00, 8'h00);
        checkOutput("abort_oe_before", bus_data_oe, 1'b1);
        curHost = 1'b1; curWe = 1'b0; curHaddr = 8'h00;
        applyStimulus();
        checkOutput("abort_oe_dropped", bus_data_oe, 1'b0);
        hostRelease();
        finishCycle();
        checkOutput("abort_rd_count", rd_count, 16'h0000);

        // Randomized traffic with occasional host operations
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                for (int k = 0; k < $urandom_range(1, 3); k++) begin
                    if ($urandom_range(0, 1) == 1) hostWrite(8'($urandom), 8'($urandom));
                    else hostRead(8'($urandom), hr);
                end
                if ($urandom_range(0, 1) == 1) hostRelease();
                else begin
                    curHost = 1'b0; curWe = 1'b0;
                end
            end else begin
                if (r < 8) a = {8'h00, 8'($urandom)};
                else       a = {8'($urandom_range(1, 255)), 8'($urandom)};
                busCycle(a, 1'($urandom), 8'($urandom), seenData, seenOe);
            end
        end
        finishCycle();
        checkEn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
